// File: rtl/ilc_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ilc_state_ctrl
// Description : Interruption/checkpoint controller that gates the design
//               clock enable and drives save/restore strobes. Optional cycle
//               breakpoint halt when ILC_BREAKPOINT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ilc_state_ctrl #(
    parameter int CNT_W          = 32,
    parameter int QUIESCE_CYCLES = 2,
    parameter int ACTION_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_req,
    input  logic             dump_req,
    input  logic             resume,
    input  logic [CNT_W-1:0] breakpoint,
    output logic             clk_en,
    output logic             save,
    output logic             restore,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int c_PH_MAX = (QUIESCE_CYCLES > ACTION_CYCLES) ? QUIESCE_CYCLES : ACTION_CYCLES;
    localparam int c_PH_W   = (c_PH_MAX < 2) ? 1 : $clog2(c_PH_MAX);
    localparam logic [c_PH_W-1:0] c_Q_LAST = c_PH_W'(QUIESCE_CYCLES - 1);
    localparam logic [c_PH_W-1:0] c_A_LAST = c_PH_W'(ACTION_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_ACTION  = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_ret_halt;
    logic              r_is_load;
    logic [c_PH_W-1:0] r_phase;
    logic              r_clk_en;
    logic              r_save;
    logic              r_restore;
    logic              r_busy;
    logic              r_done;
    logic              r_halted;
    logic [CNT_W-1:0]  r_cycle_count;
    logic              w_req;
    logic              w_bp_hit;

    assign w_req = load_req | dump_req;

`ifdef ILC_BREAKPOINT_EN
    logic w_bp_valid;
    // 0 and all-ones both mean "no breakpoint"
    assign w_bp_valid = (breakpoint != '0) && (breakpoint != '1);
    assign w_bp_hit   = w_bp_valid && r_clk_en && ((r_cycle_count + CNT_W'(1)) == breakpoint);
`else
    logic w_unused_inputs;
    assign w_unused_inputs = resume ^ (^breakpoint);
    assign w_bp_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_ret_halt    <= 1'b0;
            r_is_load     <= 1'b0;
            r_phase       <= '0;
            r_clk_en      <= 1'b1;
            r_save        <= 1'b0;
            r_restore     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_halted      <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_clk_en) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
            case (r_state)
                ST_RUN: begin
                    // Breakpoint wins so the enabled-cycle count lands exactly on target
                    if (w_bp_hit) begin
                        r_state  <= ST_HALT;
                        r_clk_en <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (w_req) begin
                        r_state    <= ST_QUIESCE;
                        r_clk_en   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_phase    <= '0;
                        r_is_load  <= load_req;
                        r_ret_halt <= 1'b0;
                    end
                end
                ST_HALT: begin
`ifdef ILC_BREAKPOINT_EN
                    if (w_req) begin
                        r_state    <= ST_QUIESCE;
                        r_busy     <= 1'b1;
                        r_phase    <= '0;
                        r_is_load  <= load_req;
                        r_ret_halt <= 1'b1;
                    end else if (resume) begin
                        r_state  <= ST_RUN;
                        r_clk_en <= 1'b1;
                        r_halted <= 1'b0;
                    end
`else
                    r_state  <= ST_RUN;
                    r_clk_en <= 1'b1;
                    r_halted <= 1'b0;
`endif
                end
                ST_QUIESCE: begin
                    if (r_phase == c_Q_LAST) begin
                        r_state   <= ST_ACTION;
                        r_phase   <= '0;
                        r_save    <= ~r_is_load;
                        r_restore <= r_is_load;
                    end else begin
                        r_phase <= r_phase + c_PH_W'(1);
                    end
                end
                ST_ACTION: begin
                    if (r_phase == c_A_LAST) begin
                        r_save    <= 1'b0;
                        r_restore <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_phase   <= '0;
                        if (r_ret_halt) begin
                            r_state  <= ST_HALT;
                            r_clk_en <= 1'b0;
                        end else begin
                            r_state  <= ST_RUN;
                            r_clk_en <= 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase + c_PH_W'(1);
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_clk_en <= 1'b1;
                end
            endcase
        end
    end

    assign clk_en      = r_clk_en;
    assign save        = r_save;
    assign restore     = r_restore;
    assign busy        = r_busy;
    assign done        = r_done;
    assign halted      = r_halted;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_ilc_state_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ilc_state_ctrl
// Description : Scoreboard bench for ilc_state_ctrl; expected output tuples
//               are queued as stimulus is driven and popped after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ilc_state_ctrl;

    localparam int c_CNT_W = 32;
    localparam int c_Q     = 2;
    localparam int c_A     = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               load_req = 1'b0;
    logic               dump_req = 1'b0;
    logic               resume = 1'b0;
    logic [c_CNT_W-1:0] breakpoint = '0;
    logic               clk_en, save, restore, busy, done, halted;
    logic [c_CNT_W-1:0] cycle_count;

    typedef struct {
        string       tag;
        logic        ce, sv, rs, by, dn, hl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_cnt    = '0;

    ilc_state_ctrl #(
        .CNT_W          (c_CNT_W),
        .QUIESCE_CYCLES (c_Q),
        .ACTION_CYCLES  (c_A)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .load_req    (load_req),
        .dump_req    (dump_req),
        .resume      (resume),
        .breakpoint  (breakpoint),
        .clk_en      (clk_en),
        .save        (save),
        .restore     (restore),
        .busy        (busy),
        .done        (done),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void push(input string tag, input logic ce, input logic sv, input logic rs,
                                 input logic by, input logic dn, input logic hl, input logic [31:0] cnt);
        exp_t e;
        e.tag = tag; e.ce = ce; e.sv = sv; e.rs = rs;
        e.by = by;   e.dn = dn; e.hl = hl; e.cnt = cnt;
        sb.push_back(e);
    endfunction

    task automatic step(input logic rst, input logic ld, input logic dp, input logic rsm);
        exp_t e;
        reset = rst; load_req = ld; dump_req = dp; resume = rsm;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL sb_empty: got no expectation, required one queued");
        end else begin
            e = sb.pop_front();
            check({e.tag, ".clk_en"},  32'(clk_en),  32'(e.ce));
            check({e.tag, ".save"},    32'(save),    32'(e.sv));
            check({e.tag, ".restore"}, 32'(restore), 32'(e.rs));
            check({e.tag, ".busy"},    32'(busy),    32'(e.by));
            check({e.tag, ".done"},    32'(done),    32'(e.dn));
            check({e.tag, ".halted"},  32'(halted),  32'(e.hl));
            check({e.tag, ".count"},   cycle_count,  e.cnt);
        end
    endtask

    task automatic do_reset(input string tag, input int n);
        m_cnt = '0;
        for (int i = 0; i < n; i++) begin
            push(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            m_cnt++;
            push(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_cnt);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One request pulse at tick 1; optional extra dump pulse at tick extra_t (0 = none).
    // Count advances once on the request edge only when starting from a running design.
    task automatic op(input string tag, input logic is_load, input logic dump_also,
                      input int extra_t, input logic from_halt, input int n_ticks);
        logic ld, dp;
        for (int t = 1; t <= n_ticks; t++) begin
            if (t == 1 && !from_halt) m_cnt++;
            if (t <= c_Q + c_A)
                push(tag, 1'b0, (t > c_Q) && !is_load, (t > c_Q) && is_load,
                     1'b1, 1'b0, from_halt, m_cnt);
            else
                push(tag, !from_halt, 1'b0, 1'b0, 1'b0, 1'b1, from_halt, m_cnt);
            ld = (t == 1) && is_load;
            dp = ((t == 1) && (dump_also || !is_load)) || (t == extra_t);
            step(1'b0, ld, dp, 1'b0);
        end
    endtask

    initial begin
        do_reset("reset", 5);
        idle("run", 10);

        op("dump", 1'b0, 1'b0, 0, 1'b0, c_Q + c_A + 1);
        idle("post_dump", 2);

        op("both", 1'b1, 1'b1, 3, 1'b0, c_Q + c_A + 1);
        idle("post_both", 2);

        // Stop in the first save cycle, then reset aborts the operation
        op("abort", 1'b0, 1'b0, 0, 1'b0, c_Q + 1);
        m_cnt = '0;
        push("abort_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle("after_abort", 3);

`ifdef ILC_BREAKPOINT_EN
        breakpoint = 32'd20;
        do_reset("bp_reset", 1);
        idle("bp_run", 19);
        m_cnt = 32'd20;
        push("bp_hit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_cnt);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            push("bp_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_cnt);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        op("halt_dump", 1'b0, 1'b0, 0, 1'b1, c_Q + c_A + 1);
        push("resume", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_cnt);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle("after_resume", 3);

        breakpoint = 32'hFFFF_FFFF;
        do_reset("bp_ones_reset", 1);
        idle("bp_ones", 100);
        breakpoint = 32'd0;
        do_reset("bp_zero_reset", 1);
        idle("bp_zero", 100);
`else
        breakpoint = 32'd5;
        do_reset("nobp_reset", 1);
        idle("nobp_run", 10);
        m_cnt++;
        push("nobp_resume", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_cnt);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle("nobp_tail", 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
